// File: rtl/icache_pkg.sv
// Shared constants and FSM state type for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned DATA_W            = 32;
  localparam int unsigned ICACHE_INDEX_BITS = 6;
  localparam int unsigned MEM_ADDR_BITS     = 18;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MISS  = 2'd1,
    S_ABORT = 2'd2
  } state_e;

endpackage

// File: rtl/icache_if.sv
// Fetcher request/response and memory refill handshake bundle.
interface icache_if;
  import icache_pkg::*;

  logic              rn;
  logic [31:0]       addr;
  logic [DATA_W-1:0] inst;
  logic              read_ready;
  logic              mem_req;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_valid;

  // The cache is the slave towards the Fetcher and drives the refill request.
  modport slave (
    input  rn, addr, mem_data, mem_valid,
    output inst, read_ready, mem_req, mem_addr
  );

  modport master (
    output rn, addr, mem_data, mem_valid,
    input  inst, read_ready, mem_req, mem_addr
  );
endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read by index, synchronous write, valid clear on rst.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned TAG_BITS   = MEM_ADDR_BITS - ICACHE_INDEX_BITS - 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_index_i,
  output logic                  rd_valid_o,
  output logic [TAG_BITS-1:0]   rd_tag_o,
  output logic [DATA_W-1:0]     rd_data_o,
  input  logic                  we_i,
  input  logic [INDEX_BITS-1:0] wr_index_i,
  input  logic [TAG_BITS-1:0]   wr_tag_i,
  input  logic [DATA_W-1:0]     wr_data_i
);

  localparam int unsigned LINES = 1 << INDEX_BITS;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [DATA_W-1:0]   data_q [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (we_i) begin
      valid_q[wr_index_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we_i) begin
      tag_q[wr_index_i]  <= wr_tag_i;
      data_q[wr_index_i] <= wr_data_i;
    end
  end

  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_data_o  = data_q[rd_index_i];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-line instruction cache: FSM, request latching, refill handshake.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = ICACHE_INDEX_BITS,
  parameter int unsigned ADDR_BITS  = MEM_ADDR_BITS
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    rdy_i,
  input  logic    clr_i,
  icache_if.slave bus
);

  localparam int unsigned TAG_BITS = ADDR_BITS - INDEX_BITS - 2;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              read_ready_q, read_ready_d;
  logic              mem_req_q, mem_req_d;
  logic [31:0]       mem_addr_q, mem_addr_d;
  logic              fill_we;

  logic                  rd_valid;
  logic [TAG_BITS-1:0]   rd_tag;
  logic [DATA_W-1:0]     rd_data;
  logic                  hit;

  // A hit is answered in the accepting cycle, so only misses need the latched
  // request address; mem_addr_q doubles as that latch for the fill index/tag.
  icache_array #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS)
  ) u_array (
    .clk        (clk),
    .rst        (rst),
    .rd_index_i (bus.addr[INDEX_BITS+1:2]),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .we_i       (fill_we && rdy_i),
    .wr_index_i (mem_addr_q[INDEX_BITS+1:2]),
    .wr_tag_i   (mem_addr_q[ADDR_BITS-1:INDEX_BITS+2]),
    .wr_data_i  (bus.mem_data)
  );

  assign hit = rd_valid && (rd_tag == bus.addr[ADDR_BITS-1:INDEX_BITS+2]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      inst_q       <= '0;
      read_ready_q <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
    end else if (rdy_i) begin
      state_q      <= state_d;
      inst_q       <= inst_d;
      read_ready_q <= read_ready_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.rn && !clr_i && !hit) state_d = S_MISS;
      S_MISS: begin
        if (bus.mem_valid)  state_d = S_IDLE;
        else if (clr_i)     state_d = S_ABORT;
      end
      S_ABORT: if (bus.mem_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    inst_d       = inst_q;
    read_ready_d = 1'b0;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fill_we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.rn && !clr_i) begin
          if (hit) begin
            inst_d       = rd_data;
            read_ready_d = 1'b1;
          end else begin
            mem_req_d  = 1'b1;
            mem_addr_d = {bus.addr[31:2], 2'b00};
          end
        end
      end
      S_MISS: begin
        if (bus.mem_valid) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
          if (!clr_i) begin
            inst_d       = bus.mem_data;
            read_ready_d = 1'b1;
          end
        end
      end
      S_ABORT: begin
        if (bus.mem_valid) begin
          fill_we   = 1'b1;
          mem_req_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign bus.inst       = inst_q;
  assign bus.read_ready = read_ready_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: vector table for the main flow plus hand sequences for rdy and rst.
module tb_icache;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy = 1'b1;
  logic clr = 1'b0;

  icache_if bus ();

  icache #(
    .INDEX_BITS (6),
    .ADDR_BITS  (18)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy_i (rdy),
    .clr_i (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        clr;
    logic        rn;
    logic [31:0] addr;
    logic        mv;
    logic [31:0] md;
    logic [31:0] e_inst;
    logic        e_rr;
    logic        e_req;
    logic [31:0] e_maddr;
  } vec_t;

  vec_t vecs[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic add(input logic r, input logic c, input logic rn, input logic [31:0] a,
                     input logic mv, input logic [31:0] md, input logic [31:0] ei,
                     input logic err, input logic ereq, input logic [31:0] ema);
    vec_t v;
    v.rdy = r; v.clr = c; v.rn = rn; v.addr = a; v.mv = mv; v.md = md;
    v.e_inst = ei; v.e_rr = err; v.e_req = ereq; v.e_maddr = ema;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic c, input logic rn, input logic [31:0] a,
                       input logic mv, input logic [31:0] md);
    rdy = r; clr = c; bus.rn = rn; bus.addr = a; bus.mem_valid = mv; bus.mem_data = md;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] ei, input logic err,
                            input logic ereq, input logic [31:0] ema);
    chk({tag, ".inst"},       bus.inst, ei);
    chk({tag, ".read_ready"}, {31'b0, bus.read_ready}, {31'b0, err});
    chk({tag, ".mem_req"},    {31'b0, bus.mem_req}, {31'b0, ereq});
    chk({tag, ".mem_addr"},   bus.mem_addr, ema);
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //  rdy clr rn  addr          mv  mem_data      inst          rr  req maddr
    add(1, 0, 1, 32'h0000_1000, 0, 32'h0,        32'h0,        0, 1, 32'h0000_1000); // 0 cold miss
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 32'h0000_1000); // 1 wait
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        0, 1, 32'h0000_1000); // 2 wait
    add(1, 0, 0, 32'h0,         1, 32'h0000_0513, 32'h0000_0513, 1, 0, 32'h0000_1000); // 3 fill
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0000_0513, 0, 0, 32'h0000_1000); // 4 pulse ends
    add(1, 0, 1, 32'h0000_1000, 0, 32'h0,        32'h0000_0513, 1, 0, 32'h0000_1000); // 5 hit
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0000_0513, 0, 0, 32'h0000_1000); // 6
    add(1, 0, 1, 32'h0000_1100, 0, 32'h0,        32'h0000_0513, 0, 1, 32'h0000_1100); // 7 conflict miss
    add(1, 0, 0, 32'h0,         1, 32'h0000_FFFF, 32'h0000_FFFF, 1, 0, 32'h0000_1100); // 8 fill
    add(1, 0, 1, 32'h0000_1100, 0, 32'h0,        32'h0000_FFFF, 1, 0, 32'h0000_1100); // 9 hit
    add(1, 0, 1, 32'h0000_1000, 0, 32'h0,        32'h0000_FFFF, 0, 1, 32'h0000_1000); // 10 evicted
    add(1, 0, 0, 32'h0,         1, 32'h0000_0513, 32'h0000_0513, 1, 0, 32'h0000_1000); // 11 refill
    add(1, 0, 1, 32'h0000_2000, 0, 32'h0,        32'h0000_0513, 0, 1, 32'h0000_2000); // 12 miss
    add(1, 1, 0, 32'h0,         0, 32'h0,        32'h0000_0513, 0, 1, 32'h0000_2000); // 13 clr -> abort
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'h0000_0513, 0, 1, 32'h0000_2000); // 14
    add(1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0513, 0, 0, 32'h0000_2000); // 15 silent fill
    add(1, 0, 1, 32'h0000_2000, 0, 32'h0,        32'hDEAD_BEEF, 1, 0, 32'h0000_2000); // 16 hit
    add(1, 0, 1, 32'h0000_3004, 0, 32'h0,        32'hDEAD_BEEF, 0, 1, 32'h0000_3004); // 17 miss idx 1
    add(1, 1, 0, 32'h0,         1, 32'hCAFE_F00D, 32'hDEAD_BEEF, 0, 0, 32'h0000_3004); // 18 clr+valid
    add(1, 0, 1, 32'h0000_3004, 0, 32'h0,        32'hCAFE_F00D, 1, 0, 32'h0000_3004); // 19 hit
    add(1, 1, 1, 32'h0000_4008, 0, 32'h0,        32'hCAFE_F00D, 0, 0, 32'h0000_3004); // 20 clr drops miss
    add(1, 1, 1, 32'h0000_2000, 0, 32'h0,        32'hCAFE_F00D, 0, 0, 32'h0000_3004); // 21 clr drops hit
    add(1, 0, 1, 32'hFFFC_2000, 0, 32'h0,        32'hDEAD_BEEF, 1, 0, 32'h0000_3004); // 22 high bits ignored
    add(1, 0, 0, 32'h0,         0, 32'h0,        32'hDEAD_BEEF, 0, 0, 32'h0000_3004); // 23

    step();
    step();
    expect_out("reset", 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].rdy, vecs[i].clr, vecs[i].rn, vecs[i].addr, vecs[i].mv, vecs[i].md);
      step();
      expect_out($sformatf("vec%0d", i), vecs[i].e_inst, vecs[i].e_rr, vecs[i].e_req, vecs[i].e_maddr);
    end

    // rdy low while a hit request is held: nothing moves until rdy returns
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'h0000_3004, 1'b0, 32'h0);
      step();
      expect_out($sformatf("rdy_hold%0d", k), 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_3004);
    end
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3004, 1'b0, 32'h0);
    step();
    expect_out("rdy_resume", 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_3004);
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      step();
      expect_out($sformatf("rdy_freeze_rr%0d", k), 32'hCAFE_F00D, 1'b1, 1'b0, 32'h0000_3004);
    end
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    expect_out("rdy_release", 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0000_3004);

    // rst in the middle of a refill
    drive(1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
    step();
    expect_out("rst_pre_miss", 32'hCAFE_F00D, 1'b0, 1'b1, 32'h0000_5000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();
    rst = 1'b1;
    step();
    expect_out("rst_mid_miss", 32'h0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1111_1111);
    step();
    expect_out("rst_stray_valid", 32'h0, 1'b0, 1'b0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_3004, 1'b0, 32'h0);
    step();
    expect_out("rst_invalidated", 32'h0, 1'b0, 1'b1, 32'h0000_3004);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
    step();
    expect_out("rst_refill", 32'h1234_5678, 1'b1, 1'b0, 32'h0000_3004);
    drive(1'b1, 1'b0, 1'b1, 32'h0000_5000, 1'b0, 32'h0);
    step();
    expect_out("rst_no_stray_fill", 32'h1234_5678, 1'b0, 1'b1, 32'h0000_5000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_0055);
    step();
    expect_out("rst_final_fill", 32'h0000_0055, 1'b1, 1'b0, 32'h0000_5000);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
